// File: rtl/pet_loader_pkg.sv
// Shared types and memory-map constants for the PET program loader.
// Holds the loader state encoding and default fixup/limit addresses.
package pet_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    FIX,
    GAP,
    DONE
  } state_t;

  localparam logic [15:0] PET_VARTAB  = 16'h002A;
  localparam logic [15:0] PET_RAM_TOP = 16'h8000;

endpackage

// File: rtl/dma_wr_hold.sv
// One-entry DMA write holding register.
// Write request stays asserted with stable address/data until accepted.
module dma_wr_hold #(
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  input  logic              i_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_data
);

  logic              r_full;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_ld) begin
      r_full <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (i_ready) begin
      r_full <= 1'b0;
    end
  end

  assign o_we   = r_full;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/prg_dma_loader.sv
// Streams a downloaded program into RAM over a DMA write port, then
// patches the end-of-program pointer pairs at PTR_BASE.
module prg_dma_loader
  import pet_loader_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] LOAD_LIMIT = ADDR_W'(PET_RAM_TOP),
  parameter logic [ADDR_W-1:0] PTR_BASE   = ADDR_W'(PET_VARTAB),
  parameter int                NUM_PTRS   = 1,
  parameter int                FIX_GAP    = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [7:0]        dma_data,
  output logic              dma_we,
  input  logic              dma_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err,
  output logic [ADDR_W-1:0] end_addr
);

  localparam logic [2:0] NP     = 3'(NUM_PTRS);
  localparam logic [2:0] NP_M1  = 3'(NUM_PTRS - 1);
  localparam logic [2:0] GAP_M1 = 3'(FIX_GAP - 1);

  state_t            r_st;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W:0]   r_cnt;
  logic [2:0]        r_idx;
  logic              r_ph;
  logic              r_sent;
  logic              r_abort;
  logic              r_ovf;
  logic              r_err;
  logic [2:0]        r_gap;

  logic              w_full;
  logic              w_free;
  logic              w_abt;
  logic              w_dat_ld;
  logic              w_fx_ld;
  logic              w_last;
  logic [ADDR_W-1:0] w_fx_addr;
  logic [7:0]        w_fx_data;

  assign w_free = !w_full || dma_ready;
  // A restart request is remembered until the in-flight beat retires.
  assign w_abt = (r_st == DRAIN || r_st == FIX || r_st == GAP)
              && (r_abort || dl_active);

  assign w_dat_ld = (r_st == LOAD) && dl_active && dl_wr && !w_full
                 && (dl_addr > 25'd1) && (r_ptr < LOAD_LIMIT);

  // r_idx/r_ph always name the next fixup byte to issue.
  assign w_fx_ld = !w_abt
                && ((r_st == FIX && !r_sent)
                 || (r_st == GAP && r_gap == 3'd0 && r_idx != NP));

  assign w_fx_addr = PTR_BASE + ADDR_W'({r_idx, r_ph});
  assign w_fx_data = r_ph ? r_end[15:8] : r_end[7:0];
  assign w_last    = (r_idx == NP_M1) && r_ph;

  dma_wr_hold #(
    .ADDR_W (ADDR_W)
  ) u_hold (
    .i_clk   (clk_sys),
    .i_rst   (reset),
    .i_ld    (w_dat_ld || w_fx_ld),
    .i_addr  (w_dat_ld ? r_ptr : w_fx_addr),
    .i_data  (w_dat_ld ? dl_data : w_fx_data),
    .i_ready (dma_ready),
    .o_we    (w_full),
    .o_addr  (dma_addr),
    .o_data  (dma_data)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_st    <= IDLE;
      r_ptr   <= '0;
      r_end   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ph    <= 1'b0;
      r_sent  <= 1'b0;
      r_abort <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_gap   <= '0;
    end else if (w_abt) begin
      if (w_free) begin
        r_st    <= LOAD;
        r_ptr   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_err   <= 1'b0;
        r_sent  <= 1'b0;
        r_abort <= 1'b0;
      end else begin
        r_abort <= 1'b1;
      end
    end else begin
      unique case (r_st)
        IDLE: if (dl_active) begin
          r_st  <= LOAD;
          r_ptr <= '0;
          r_cnt <= '0;
          r_ovf <= 1'b0;
          r_err <= 1'b0;
        end
        LOAD: if (!dl_active) begin
          r_st <= DRAIN;
        end else if (dl_wr) begin
          if (w_full)
            r_err <= 1'b1;
          else if (dl_addr == 25'd0)
            r_ptr <= ADDR_W'({r_ptr[15:8], dl_data});
          else if (dl_addr == 25'd1)
            r_ptr <= ADDR_W'({dl_data, r_ptr[7:0]});
          else if (w_dat_ld) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end else
            r_ovf <= 1'b1;
        end
        DRAIN: if (!w_full) begin
          r_end  <= r_ptr;
          r_idx  <= '0;
          r_ph   <= 1'b0;
          r_sent <= 1'b0;
          if (r_cnt == '0) begin
            r_err <= 1'b1;
            r_st  <= DONE;
          end else begin
            r_st <= FIX;
          end
        end
        FIX: if (w_fx_ld) begin
          r_sent <= 1'b1;
        end else if (w_full && dma_ready) begin
          r_sent        <= 1'b0;
          {r_idx, r_ph} <= {r_idx, r_ph} + 4'd1;
          if (FIX_GAP > 0) begin
            r_st  <= GAP;
            r_gap <= GAP_M1;
          end else if (w_last) begin
            r_st <= DONE;
          end
        end
        // The next beat loads on the last gap cycle so it appears right after.
        GAP: if (r_gap != 3'd0) begin
          r_gap <= r_gap - 3'd1;
        end else if (r_idx == NP) begin
          r_st <= DONE;
        end else begin
          r_st   <= FIX;
          r_sent <= 1'b1;
        end
        DONE: r_st <= IDLE;
        default: r_st <= IDLE;
      endcase
    end
  end

  assign dl_wait  = w_full;
  assign dma_we   = w_full;
  assign busy     = (r_st != IDLE);
  assign done     = (r_st == DONE);
  assign overflow = r_ovf;
  assign err      = r_err;
  assign end_addr = r_end;

endmodule

// File: tb/tb_prg_dma_loader.sv
// Randomized scoreboard bench for prg_dma_loader with a byte-list
// reference model; a negedge monitor checks every accepted DMA write.
module tb_prg_dma_loader;

  localparam int NP   = 3;
  localparam int FG   = 2;
  localparam int BASE = 'h2A;
  localparam int LIM  = 'h8000;

  typedef logic [7:0] bq_t[$];

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dma_ready = 1'b1;
  logic        dl_wait;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_we;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        err;
  logic [15:0] end_addr;

  int total = 0;
  int bad = 0;
  int rmode = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic [23:0] exp_q[$];
  int m_end;
  bit m_ovf;
  bit m_err;

  prg_dma_loader #(
    .ADDR_W   (16),
    .NUM_PTRS (NP),
    .FIX_GAP  (FG)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_wait   (dl_wait),
    .dma_addr  (dma_addr),
    .dma_data  (dma_data),
    .dma_we    (dma_we),
    .dma_ready (dma_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .err       (err),
    .end_addr  (end_addr)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference model: what a load of these bytes must write to RAM.
  function automatic void model(input bq_t b, input int nfix);
    int p;
    int cnt;
    p = 0;
    cnt = 0;
    m_ovf = 0;
    foreach (b[i]) begin
      if (i == 0) p = (p & 'hFF00) | int'(b[i]);
      else if (i == 1) p = (p & 'h00FF) | (int'(b[i]) << 8);
      else if (p < LIM) begin
        exp_q.push_back({p[15:0], b[i]});
        p = (p + 1) & 'hFFFF;
        cnt++;
      end else m_ovf = 1;
    end
    m_end = p;
    m_err = (cnt == 0);
    if (cnt > 0)
      for (int k = 0; k < 2 * NP && k < nfix; k++)
        exp_q.push_back({16'(BASE + k), (k % 2 == 1) ? 8'(p >> 8) : 8'(p)});
  endfunction

  function automatic bq_t hdr(input int p, input int n, input bit rnd);
    bq_t q;
    q.push_back(8'(p));
    q.push_back(8'(p >> 8));
    for (int k = 0; k < n; k++)
      q.push_back(rnd ? 8'($urandom) : 8'(8'hAA + 8'h11 * k));
    return q;
  endfunction

  task automatic wait_free();
    int n;
    n = 0;
    while (dl_wait === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL wait_free: dl_wait stuck 1 want 0");
    end
  endtask

  task automatic send(input bq_t b);
    foreach (b[i]) begin
      wait_free();
      dl_wr = 1'b1;
      dl_addr = 25'(i);
      dl_data = b[i];
      tick();
      dl_wr = 1'b0;
    end
  endtask

  task automatic start();
    dl_active = 1'b1;
    tick();
  endtask

  task automatic finish_load(input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    dl_active = 1'b0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL %s_done_timeout: done 0 want 1", tag);
    end else begin
      chk({tag, "_end"}, end_addr, m_end);
      chk({tag, "_ovf"}, overflow, m_ovf);
      chk({tag, "_err"}, err, m_err);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_left"}, exp_q.size(), 0);
    end
    tick();
    chk({tag, "_idle"}, busy, 0);
    tick();
    chk({tag, "_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wait"}, dl_wait, 0);
    chk({tag, "_we"}, dma_we, 0);
    chk({tag, "_addr"}, dma_addr, 0);
    chk({tag, "_data"}, dma_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_end"}, end_addr, 0);
  endtask

  initial begin
    forever begin
      tick();
      case (rmode)
        0: dma_ready = 1'b1;
        1: dma_ready = ($urandom_range(0, 3) != 0);
        default: dma_ready = 1'b0;
      endcase
    end
  end

  initial begin
    logic p_stall;
    logic [15:0] p_addr;
    logic [7:0] p_data;
    logic [23:0] e;
    int idle;
    bit p_fix;
    bit f;
    p_stall = 0;
    p_addr = '0;
    p_data = '0;
    idle = 0;
    p_fix = 0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        p_stall = 0;
        p_fix = 0;
        idle = 0;
      end else begin
        chk("wait_eq_we", dl_wait, dma_we);
        if (p_stall) begin
          chk("stall_we", dma_we, 1);
          chk("stall_addr", dma_addr, p_addr);
          chk("stall_data", dma_data, p_data);
        end
        if (done) done_cnt++;
        if (dma_we && dma_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexp_write: got %h=%h want none", dma_addr, dma_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", dma_addr, e[23:8]);
            chk("wr_data", dma_data, e[7:0]);
          end
          f = (dma_addr >= BASE) && (dma_addr < BASE + 2 * NP);
          if (f && p_fix) chk("fix_gap", idle, FG);
          p_fix = f;
          idle = 0;
        end else if (!dma_we) begin
          idle++;
        end
        p_stall = dma_we && !dma_ready;
        p_addr = dma_addr;
        p_data = dma_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    bq_t q2;
    int d0;
    int a0;
    int n;
    int p;

    tick();
    tick();
    chk_zero("rst");
    reset = 1'b0;
    tick();

    rmode = 0;
    q = hdr('h0401, 3, 0);
    model(q, 99);
    start();
    send(q);
    finish_load("basic");

    rmode = 2;
    q = hdr('h0401, 3, 0);
    model(q, 99);
    start();
    fork
      send(q);
      begin
        repeat (7) tick();
        chk("stall_we_hi", dma_we, 1);
        chk("stall_wait_hi", dl_wait, 1);
        chk("stall_a", dma_addr, 'h0401);
        repeat (2) tick();
        rmode = 0;
      end
    join
    finish_load("stall");

    q = hdr('h7FFE, 4, 0);
    model(q, 99);
    start();
    send(q);
    finish_load("limit");

    q = hdr('h0500, 0, 0);
    model(q, 99);
    start();
    send(q);
    finish_load("hdronly");

    rmode = 2;
    q = hdr('h1234, 1, 0);
    model(q, 99);
    m_err = 1;
    start();
    send(q);
    dl_wr = 1'b1;
    dl_addr = 25'd3;
    dl_data = 8'h55;
    tick();
    dl_wr = 1'b0;
    chk("proto_err", err, 1);
    rmode = 0;
    finish_load("proto");

    rmode = 2;
    q = hdr('h2000, 1, 0);
    start();
    send(q);
    dl_wr = 1'b1;
    dl_addr = 25'd3;
    tick();
    dl_wr = 1'b0;
    chk("pre_rst_we", dma_we, 1);
    chk("pre_rst_err", err, 1);
    reset = 1'b1;
    dl_active = 1'b0;
    tick();
    chk_zero("midrst");
    reset = 1'b0;
    rmode = 0;
    tick();
    q = hdr('h0300, 3, 1);
    model(q, 99);
    start();
    send(q);
    finish_load("postrst");

    d0 = done_cnt;
    a0 = acc_cnt;
    q = hdr('h7FFF, 3, 0);
    model(q, 1);
    start();
    send(q);
    dl_active = 1'b0;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 300) begin
      tick();
      n++;
    end
    chk("abort_reach", acc_cnt - a0, 2);
    dl_active = 1'b1;
    tick();
    tick();
    chk("abort_ovf", overflow, 0);
    chk("abort_err", err, 0);
    chk("abort_we", dma_we, 0);
    chk("abort_busy", busy, 1);
    chk("abort_nodone", done_cnt - d0, 0);
    q2 = hdr('h0600, 2, 1);
    model(q2, 99);
    send(q2);
    finish_load("reload");
    chk("abort_pulses", done_cnt - d0, 1);

    rmode = 1;
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 3))
        0: p = 'h7FF0 + $urandom_range(0, 15);
        1: p = 'h8000 + $urandom_range(0, 255);
        default: p = $urandom_range('h0100, 'h7F00);
      endcase
      q = hdr(p, $urandom_range(0, 10), 1);
      model(q, 99);
      start();
      send(q);
      finish_load("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
